// File: rtl/reg7_enable.sv
// rtl/reg7_enable.sv - WIDTH-bit storage register with synchronous active-low reset and load enable
module reg7_enable #(
    parameter int unsigned     WIDTH       = 7,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic [WIDTH-1:0] D,
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] Q
);

    // Case-equality on enable so an unknown enable holds rather than loading X.
    always_ff @(posedge clk) begin
        if (!reset) begin
            Q <= RESET_VALUE;
        end else if (enable === 1'b1) begin
            Q <= D;
        end
    end

endmodule

// File: tb/tb_reg7_enable.sv
// tb/tb_reg7_enable.sv - self-checking bench for reg7_enable
module tb_reg7_enable;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] D;
    logic       enable;
    logic [6:0] Q;

    int total = 0;
    int bad   = 0;
    logic [6:0] model_q;

    always #10 clk = ~clk;

    reg7_enable dut (
        .D      (D),
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .Q      (Q)
    );

    // Advance one rising edge; the model applies the register's rules to the pre-edge inputs.
    task automatic step();
        if (reset === 1'b0)
            model_q = 7'b0;
        else if (enable === 1'b1)
            model_q = D;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b0; D = 7'b1111000; enable = 1'b1;
        step();
        total++;
        if (Q !== 7'b0000000) begin
            bad++;
            $display("FAIL reset_clear: Q=%b expected=%b", Q, 7'b0000000);
        end
    endtask

    task automatic test_load();
        reset = 1'b1; enable = 1'b1; D = 7'b0000001;
        step();
        total++;
        if (Q !== 7'b0000001) begin
            bad++;
            $display("FAIL load_first: Q=%b expected=%b", Q, 7'b0000001);
        end
        D = 7'b1111000;
        step();
        total++;
        if (Q !== 7'b1111000) begin
            bad++;
            $display("FAIL load_second: Q=%b expected=%b", Q, 7'b1111000);
        end
    endtask

    task automatic test_hold();
        reset = 1'b1; enable = 1'b0; D = 7'b0000111;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (Q !== 7'b1111000) begin
                bad++;
                $display("FAIL hold_edge%0d: Q=%b expected=%b", i, Q, 7'b1111000);
            end
        end
    endtask

    task automatic test_reset_dominates();
        reset = 1'b0; enable = 1'b1; D = 7'b0000111;
        step();
        total++;
        if (Q !== 7'b0000000) begin
            bad++;
            $display("FAIL reset_dominates: Q=%b expected=%b", Q, 7'b0000000);
        end
    endtask

    task automatic test_sync_only();
        reset = 1'b1; enable = 1'b1; D = 7'b1010101;
        step();
        total++;
        if (Q !== 7'b1010101) begin
            bad++;
            $display("FAIL sync_preload: Q=%b expected=%b", Q, 7'b1010101);
        end
        enable = 1'b0;
        reset  = 1'b0;
        #5;
        reset  = 1'b1;
        #1;
        total++;
        if (Q !== 7'b1010101) begin
            bad++;
            $display("FAIL sync_glitch_between_edges: Q=%b expected=%b", Q, 7'b1010101);
        end
        step();
        total++;
        if (Q !== 7'b1010101) begin
            bad++;
            $display("FAIL sync_after_glitch_edge: Q=%b expected=%b", Q, 7'b1010101);
        end
    endtask

    task automatic test_release_enable_low();
        reset = 1'b0; enable = 1'b0; D = 7'b0000001;
        step();
        total++;
        if (Q !== 7'b0000000) begin
            bad++;
            $display("FAIL release_in_reset: Q=%b expected=%b", Q, 7'b0000000);
        end
        reset = 1'b1;
        step();
        total++;
        if (Q !== 7'b0000000) begin
            bad++;
            $display("FAIL release_enable_low: Q=%b expected=%b", Q, 7'b0000000);
        end
        enable = 1'b1;
        step();
        total++;
        if (Q !== 7'b0000001) begin
            bad++;
            $display("FAIL release_then_load: Q=%b expected=%b", Q, 7'b0000001);
        end
    endtask

    task automatic test_enable_x();
        reset = 1'b1; enable = 1'b1; D = 7'b0110011;
        step();
        enable = 1'bx; D = 7'b1001100;
        step();
        total++;
        if (Q !== 7'b0110011 || $isunknown(Q)) begin
            bad++;
            $display("FAIL enable_x_holds: Q=%b expected=%b", Q, 7'b0110011);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            reset  = ($urandom_range(0, 7) != 0);
            enable = $urandom_range(0, 1) == 1;
            D      = 7'($urandom);
            step();
            total++;
            if (Q !== model_q) begin
                bad++;
                $display("FAIL random_%0d: Q=%b expected=%b (reset=%b enable=%b D=%b)",
                         i, Q, model_q, reset, enable, D);
            end
        end
    endtask

    initial begin
        model_q = 7'b0;
        reset = 1'b0; D = 7'b0; enable = 1'b0;
        test_reset();
        test_load();
        test_hold();
        test_reset_dominates();
        test_sync_only();
        test_release_enable_low();
        test_enable_x();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
